// File: rtl/buzzer_alert_scheduler.sv
// buzzer_alert_scheduler
// Shares one physical buzzer between the timer and alarm alert requests.
// Requests are latched as pending flags. The timer has priority over the alarm.
// While an alert rings, the buzzer beeps BEEP_ON cycles high and BEEP_OFF cycles low.
// Stop and snooze buttons end an alert, and an alert times out after RING_SECS cycles.
// A background countdown re-arms the alarm after SNOOZE_SECS cycles.
// The parameters must fit the fixed output widths:
//   SNOOZE_SECS must fit in 9 bits.
//   MAX_SNOOZE must fit in 2 bits.
module buzzer_alert_scheduler #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned BEEP_ON     = 1,
  parameter int unsigned BEEP_OFF    = 1,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_req,
  input  logic       alarm_req,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic       snooze_active,
  output logic [8:0] snooze_left,
  output logic [1:0] snooze_cnt,
  output logic       missed
);

  localparam int unsigned RC_W = $clog2(RING_SECS + 1);
  localparam int unsigned PH_W = $clog2(BEEP_ON + BEEP_OFF + 1);
  localparam int unsigned SL_W = $clog2(SNOOZE_SECS + 1);
  localparam int unsigned SC_W = $clog2(MAX_SNOOZE + 1);

  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);
  localparam logic [PH_W-1:0] PH_ON     = PH_W'(BEEP_ON);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [SL_W-1:0] SNZ_LOAD  = SL_W'(SNOOZE_SECS);
  localparam logic [SL_W-1:0] SNZ_ONE   = SL_W'(1);
  localparam logic [SC_W-1:0] SNZ_MAX   = SC_W'(MAX_SNOOZE);
  localparam logic [SC_W-1:0] SNZ_INC   = SC_W'(1);
  localparam logic [RC_W-1:0] RC_INC    = RC_W'(1);
  localparam logic [PH_W-1:0] PH_INC    = PH_W'(1);

  // The state encoding doubles as the active_src code.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RING_T = 2'b01,
    S_RING_A = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_pend_t;
  logic            r_pend_a;
  logic [RC_W-1:0] r_ring_cnt;
  logic [PH_W-1:0] r_phase;
  logic            r_buzzer;
  logic            r_missed;

  logic            r_snz_active;
  logic [SL_W-1:0] r_snz_left;
  logic [SC_W-1:0] r_snz_cnt;

  logic            r_timer_d;
  logic            r_alarm_d;
  logic            r_stop_d;
  logic            r_snz_btn_d;

  logic            w_t_rise;
  logic            w_a_rise;
  logic            w_stop_rise;
  logic            w_snz_rise;
  logic            w_in_t;
  logic            w_in_a;
  logic            w_timeout;
  logic            w_snz_ok;
  logic            w_t_end;
  logic            w_a_end;
  logic            w_a_kill;
  logic            w_a_snz;
  logic            w_snz_expire;

  // Registered copies of the requests and buttons, used for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer_d   <= 1'b0;
      r_alarm_d   <= 1'b0;
      r_stop_d    <= 1'b0;
      r_snz_btn_d <= 1'b0;
    end else begin
      r_timer_d   <= timer_req;
      r_alarm_d   <= alarm_req;
      r_stop_d    <= stop_btn;
      r_snz_btn_d <= snooze_btn;
    end
  end

  assign w_t_rise    = timer_req  & ~r_timer_d;
  assign w_a_rise    = alarm_req  & ~r_alarm_d;
  assign w_stop_rise = stop_btn   & ~r_stop_d;
  assign w_snz_rise  = snooze_btn & ~r_snz_btn_d;

  assign w_in_t    = (r_state == S_RING_T);
  assign w_in_a    = (r_state == S_RING_A);
  assign w_timeout = (w_in_t | w_in_a) & (r_ring_cnt == RING_LAST);
  assign w_snz_ok  = (r_snz_cnt < SNZ_MAX);

  // The current timer alert ends on a stop press or on timeout.
  assign w_t_end  = w_in_t & (w_stop_rise | w_timeout);

  // The current alarm alert ends on stop, timeout or any snooze press.
  assign w_a_end  = w_in_a & (w_stop_rise | w_timeout | w_snz_rise);

  // An alarm end that counts as a stop also wipes the snooze bookkeeping.
  // A snooze press after the snooze budget is used up counts as a stop.
  assign w_a_kill = w_in_a & (w_stop_rise | w_timeout | (w_snz_rise & ~w_snz_ok));
  assign w_a_snz  = w_a_end & ~w_a_kill;

  assign w_snz_expire = r_snz_active & (r_snz_left == SNZ_ONE);

  // Main FSM: pending flags, state, ring timer, beep pattern and the missed flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pend_t   <= 1'b0;
      r_pend_a   <= 1'b0;
      r_ring_cnt <= '0;
      r_phase    <= '0;
      r_buzzer   <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      // A new rise wins over a clear arriving in the same cycle.
      if (w_t_rise)
        r_pend_t <= 1'b1;
      else if (w_t_end)
        r_pend_t <= 1'b0;

      if (w_a_rise || w_snz_expire)
        r_pend_a <= 1'b1;
      else if (w_a_end)
        r_pend_a <= 1'b0;

      if (w_stop_rise)
        r_missed <= 1'b0;
      else if (w_timeout)
        r_missed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_buzzer   <= 1'b0;
          r_ring_cnt <= '0;
          r_phase    <= '0;
          if (r_pend_t)
            r_state <= S_RING_T;
          else if (r_pend_a)
            r_state <= S_RING_A;
        end

        S_RING_T: begin
          if (w_t_end) begin
            r_buzzer   <= 1'b0;
            r_ring_cnt <= '0;
            r_phase    <= '0;
            r_state    <= r_pend_a ? S_RING_A : S_IDLE;
          end else begin
            r_buzzer   <= (r_phase < PH_ON);
            r_phase    <= (r_phase == PH_LAST) ? '0 : r_phase + PH_INC;
            r_ring_cnt <= r_ring_cnt + RC_INC;
          end
        end

        S_RING_A: begin
          if (w_a_end) begin
            r_buzzer   <= 1'b0;
            r_ring_cnt <= '0;
            r_phase    <= '0;
            r_state    <= r_pend_t ? S_RING_T : S_IDLE;
          end else if (w_t_rise) begin
            // Timer preempts the alarm. The alarm stays pending and restarts its window later.
            r_buzzer   <= 1'b0;
            r_ring_cnt <= '0;
            r_phase    <= '0;
            r_state    <= S_RING_T;
          end else begin
            r_buzzer   <= (r_phase < PH_ON);
            r_phase    <= (r_phase == PH_LAST) ? '0 : r_phase + PH_INC;
            r_ring_cnt <= r_ring_cnt + RC_INC;
          end
        end

        default: begin
          r_buzzer   <= 1'b0;
          r_ring_cnt <= '0;
          r_phase    <= '0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Snooze countdown, which runs independently of the ring state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snz_active <= 1'b0;
      r_snz_left   <= '0;
      r_snz_cnt    <= '0;
    end else if (w_a_rise || w_a_kill) begin
      // A fresh alarm event or a stop of the alarm discards any snooze history.
      r_snz_active <= 1'b0;
      r_snz_left   <= '0;
      r_snz_cnt    <= '0;
    end else if (w_a_snz) begin
      r_snz_active <= 1'b1;
      r_snz_left   <= SNZ_LOAD;
      r_snz_cnt    <= r_snz_cnt + SNZ_INC;
    end else if (r_snz_active) begin
      r_snz_left <= r_snz_left - SNZ_ONE;
      if (w_snz_expire)
        r_snz_active <= 1'b0;
    end
  end

  assign buzzer        = r_buzzer;
  assign active_src    = r_state;
  assign snooze_active = r_snz_active;
  assign snooze_left   = 9'(r_snz_left);
  assign snooze_cnt    = 2'(r_snz_cnt);
  assign missed        = r_missed;

endmodule

// File: tb/tb_buzzer_alert_scheduler.sv
// tb_buzzer_alert_scheduler
// Directed bench for buzzer_alert_scheduler with the default parameters.
// Each step pushes its expected outputs to a queue, advances the clock and pops/compares.
module tb_buzzer_alert_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       timer_req;
  logic       alarm_req;
  logic       stop_btn;
  logic       snooze_btn;
  logic       buzzer;
  logic [1:0] active_src;
  logic       snooze_active;
  logic [8:0] snooze_left;
  logic [1:0] snooze_cnt;
  logic       missed;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  buzzer_alert_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .timer_req     (timer_req),
    .alarm_req     (alarm_req),
    .stop_btn      (stop_btn),
    .snooze_btn    (snooze_btn),
    .buzzer        (buzzer),
    .active_src    (active_src),
    .snooze_active (snooze_active),
    .snooze_left   (snooze_left),
    .snooze_cnt    (snooze_cnt),
    .missed        (missed)
  );

  always #5 clk = ~clk;

  // Bound the run time.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  localparam int BUZ = 0, SRC = 1, SA = 2, SL = 3, SC = 4, MS = 5;

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] o;
    case (sel)
      BUZ:     o = {31'd0, buzzer};
      SRC:     o = {30'd0, active_src};
      SA:      o = {31'd0, snooze_active};
      SL:      o = {23'd0, snooze_left};
      SC:      o = {30'd0, snooze_cnt};
      MS:      o = {31'd0, missed};
      default: o = 'x;
    endcase
    return o;
  endfunction

  task automatic push(input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_all(input logic b, input logic [1:0] s, input logic sa,
                          input logic [8:0] sl, input logic [1:0] sc, input logic ms,
                          input string tag);
    push(BUZ, {31'd0, b},  {tag, ".buzzer"});
    push(SRC, {30'd0, s},  {tag, ".active_src"});
    push(SA,  {31'd0, sa}, {tag, ".snooze_active"});
    push(SL,  {23'd0, sl}, {tag, ".snooze_left"});
    push(SC,  {30'd0, sc}, {tag, ".snooze_cnt"});
    push(MS,  {31'd0, ms}, {tag, ".missed"});
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_assert++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
      end
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b0;
    timer_req  = 1'b0;
    alarm_req  = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;

    // Reset state
    step(2);
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b0, "reset");
    check_all();
    reset = 1'b1;

    // 1: alarm with no buttons times out after 60 ring cycles
    alarm_req = 1'b1;
    push(SRC, 32'd0, "t1.latch_src");
    step(1);
    check_all();
    alarm_req = 1'b0;
    push(SRC, 32'd2, "t1.entry_src");
    push(BUZ, 32'd0, "t1.entry_buz");
    step(1);
    check_all();
    for (int i = 1; i <= 59; i++) begin
      push(BUZ, (i % 2 == 1) ? 32'd1 : 32'd0, "t1.beep");
      push(SRC, 32'd2, "t1.ring_src");
      push(MS,  32'd0, "t1.ring_missed");
      step(1);
      check_all();
    end
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b1, "t1.timeout");
    step(1);
    check_all();
    stop_btn = 1'b1;
    push(MS,  32'd0, "t1.stop_clears_missed");
    push(SRC, 32'd0, "t1.idle_stop_src");
    step(1);
    check_all();
    stop_btn = 1'b0;

    // 2: snooze five cycles into the ring, countdown, then re-ring
    alarm_req = 1'b1;
    step(1);
    alarm_req = 1'b0;
    push(SRC, 32'd2, "t2.entry_src");
    step(1);
    check_all();
    step(5);
    snooze_btn = 1'b1;
    push_all(1'b0, 2'b00, 1'b1, 9'd300, 2'd1, 1'b0, "t2.snooze");
    step(1);
    check_all();
    snooze_btn = 1'b0;
    for (int k = 1; k <= 299; k++) begin
      push(SL,  32'(300 - k), "t2.count");
      push(SA,  32'd1, "t2.count_active");
      push(SRC, 32'd0, "t2.count_src");
      step(1);
      check_all();
    end
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd1, 1'b0, "t2.expire");
    step(1);
    check_all();
    push(SRC, 32'd2, "t2.rering_src");
    push(BUZ, 32'd0, "t2.rering_buz");
    push(SC,  32'd1, "t2.rering_cnt");
    step(1);
    check_all();
    push(BUZ, 32'd1, "t2.rering_beep");
    step(1);
    check_all();

    // 3: snooze presses 2 and 3 re-arm, and press 4 acts as stop
    for (int p = 2; p <= 3; p++) begin
      snooze_btn = 1'b1;
      push_all(1'b0, 2'b00, 1'b1, 9'd300, 2'(p), 1'b0, "t3.snooze");
      step(1);
      check_all();
      snooze_btn = 1'b0;
      step(299);
      push(SL, 32'd1, "t3.almost");
      check_all();
      push(SA, 32'd0, "t3.expire_active");
      push(SC, 32'(p), "t3.expire_cnt");
      step(1);
      check_all();
      push(SRC, 32'd2, "t3.rering_src");
      step(1);
      check_all();
    end
    snooze_btn = 1'b1;
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b0, "t3.fourth_is_stop");
    step(1);
    check_all();
    snooze_btn = 1'b0;
    step(3);
    push(SRC, 32'd0, "t3.stays_idle");
    push(SA,  32'd0, "t3.stays_idle_sa");
    check_all();

    // 4: timer preempts the alarm, and the alarm returns with a fresh window
    alarm_req = 1'b1;
    step(1);
    alarm_req = 1'b0;
    push(SRC, 32'd2, "t4.alarm_src");
    step(1);
    check_all();
    step(3);
    timer_req = 1'b1;
    push(SRC, 32'd1, "t4.preempt_src");
    push(BUZ, 32'd0, "t4.preempt_buz");
    step(1);
    check_all();
    push(SRC, 32'd1, "t4.timer_src");
    push(BUZ, 32'd1, "t4.timer_beep");
    step(1);
    check_all();
    snooze_btn = 1'b1;
    push(SRC, 32'd1, "t4.snooze_ignored_src");
    push(SA,  32'd0, "t4.snooze_ignored_sa");
    push(SC,  32'd0, "t4.snooze_ignored_cnt");
    step(1);
    check_all();
    snooze_btn = 1'b0;
    stop_btn = 1'b1;
    push(SRC, 32'd2, "t4.back_to_alarm");
    push(BUZ, 32'd0, "t4.back_entry_buz");
    step(1);
    check_all();
    push(SRC, 32'd2, "t4.held_stop_once");
    push(BUZ, 32'd1, "t4.alarm_beep");
    step(1);
    check_all();
    push(SRC, 32'd2, "t4.held_stop_twice");
    step(1);
    check_all();
    stop_btn = 1'b0;
    step(56);
    push(SRC, 32'd2, "t4.fresh_window");
    push(MS,  32'd0, "t4.fresh_missed");
    check_all();
    stop_btn = 1'b1;
    push(SRC, 32'd0, "t4.second_stop");
    push(MS,  32'd0, "t4.second_stop_missed");
    step(1);
    check_all();
    stop_btn  = 1'b0;
    timer_req = 1'b0;
    step(2);
    push(SRC, 32'd0, "t4.stays_idle");
    check_all();

    // 5: stop and snooze in the same cycle, where stop wins
    alarm_req = 1'b1;
    step(1);
    alarm_req = 1'b0;
    step(3);
    push(SRC, 32'd2, "t5.ringing");
    check_all();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b0, "t5.stop_wins");
    step(1);
    check_all();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    step(2);
    push(SRC, 32'd0, "t5.idle");
    push(SA,  32'd0, "t5.idle_sa");
    check_all();

    // 6: asynchronous reset while the timer rings and a snooze is counting
    alarm_req = 1'b1;
    step(1);
    alarm_req = 1'b0;
    step(2);
    snooze_btn = 1'b1;
    push(SA, 32'd1, "t6.snoozed");
    step(1);
    check_all();
    snooze_btn = 1'b0;
    timer_req = 1'b1;
    step(3);
    push(SRC, 32'd1, "t6.timer_ringing");
    push(SA,  32'd1, "t6.snooze_running");
    check_all();
    #2;
    reset = 1'b0;
    #1;
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b0, "t6.async");
    check_all();
    timer_req = 1'b0;
    step(2);
    push_all(1'b0, 2'b00, 1'b0, 9'd0, 2'd0, 1'b0, "t6.held");
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 310; i++) begin
      push(SRC, 32'd0, "t6.no_rering_src");
      push(SA,  32'd0, "t6.no_rering_sa");
      push(BUZ, 32'd0, "t6.no_rering_buz");
      step(1);
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
